// File: rtl/ch_arb_pkg.sv
// Shared types and helpers for the channel round-robin arbiter.
package ch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int N_CH_DEF     = 16;
    localparam int MAX_HOLD_DEF = 255;

    // Widest one-hot vector onehot2idx accepts; callers zero-extend into it.
    localparam int ONEHOT_MAX   = 64;
    localparam int ONEHOT_IDX_W = 6;

    // Binary index of the set bit of a one-hot vector (0 when the vector is empty).
    function automatic logic [ONEHOT_IDX_W-1:0] onehot2idx(input logic [ONEHOT_MAX-1:0] oh);
        logic [ONEHOT_IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            if (oh[i]) begin
                r = r | ONEHOT_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ch_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_pick
    import ch_arb_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N_CH-1:0]  onehot
);

    logic [N_CH-1:0] rot;
    logic [N_CH-1:0] sel;

    // Modular add that keeps the result inside 0..N_CH-1 for any N_CH.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(N_CH)) begin
            s = s - (IDX_W+1)'(N_CH);
        end
        return s[IDX_W-1:0];
    endfunction

    // Rotate right by ptr so the search start lands on bit 0, take lowest set bit, rotate back.
    always_comb begin
        rot    = '0;
        onehot = '0;
        for (int i = 0; i < N_CH; i++) begin
            rot[i] = req[wrap_add(IDX_W'(i), ptr)];
        end
        sel = rot & (~rot + N_CH'(1));
        for (int i = 0; i < N_CH; i++) begin
            onehot[wrap_add(IDX_W'(i), ptr)] = sel[i];
        end
        found = |req;
        idx   = IDX_W'(onehot2idx(ONEHOT_MAX'(onehot)));
    end

endmodule

// File: rtl/ch_rr_arbiter.sv
// Round-robin arbiter handing one channel resource to N_CH requesters with a
// registered one-hot grant, a one-cycle guard gap between owners and an
// optional hold-time limit.
module ch_rr_arbiter
    import ch_arb_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int IDX_W    = $clog2(N_CH),
    parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [N_CH-1:0]  req_i,
    input  logic             done_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             timeout_o
);

    localparam int               HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_HOLD);
    localparam logic             HOLD_EN   = (MAX_HOLD != 0);

    arb_state_e       state_reg;
    logic [N_CH-1:0]  gnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_reg;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_CH-1:0]  pick_onehot;

    logic             rel_abort;
    logic             rel_timeout;
    logic             rel_any;
    logic [IDX_W-1:0] ptr_next;

    rr_pick #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_reg),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Release conditions for the current owner and the pointer just past it.
    always_comb begin
        rel_abort   = ~req_i[idx_reg];
        rel_timeout = HOLD_EN && (cnt_reg == CNT_LAST);
        rel_any     = done_i || rel_abort || rel_timeout;
        ptr_next    = (idx_reg == IDX_W'(N_CH - 1)) ? '0 : idx_reg + IDX_W'(1);
    end

    // Arbitration FSM with registered grant, index, pointer, hold counter and timeout pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            idx_reg     <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE, RELEASE: begin
                    if (enable_i && pick_found) begin
                        gnt_reg   <= pick_onehot;
                        idx_reg   <= pick_idx;
                        cnt_reg   <= '0;
                        state_reg <= GRANT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    if (cnt_reg < CNT_MAX) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    if (rel_any) begin
                        gnt_reg     <= '0;
                        ptr_reg     <= ptr_next;
                        state_reg   <= RELEASE;
                        timeout_reg <= ~done_i & ~rel_abort & rel_timeout;
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_reg;
    assign gnt_valid_o = |gnt_reg;
    assign gnt_idx_o   = idx_reg;
    assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_ch_rr_arbiter.sv
// Scoreboard bench for ch_rr_arbiter: directed scenarios plus random traffic,
// each cycle's expected outputs come from a behavioural owner/pointer model.
module tb_ch_rr_arbiter;

    localparam int N    = 16;
    localparam int MAXH = 4;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [3:0]   idx;
        logic         to;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic [3:0]   gnt_idx_o;
    logic         timeout_o;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    // Reference model: who owns the channel, where the search starts, how long held.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    int   m_idx   = 0;
    logic m_to    = 1'b0;

    ch_rr_arbiter #(
        .N_CH     (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o),
        .timeout_o   (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_update(input logic r, input logic en, input logic [N-1:0] rq, input logic d);
        bit tmo;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_idx   = 0;
            m_to    = 1'b0;
        end else if (m_owner >= 0) begin
            m_held = m_held + 1;
            tmo = (MAXH != 0) && (m_held >= MAXH);
            if (d || !rq[m_owner] || tmo) begin
                m_to    = !d && rq[m_owner] && tmo;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            if (en && rq != '0) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (rq[c]) begin
                        m_owner = c;
                        m_idx   = c;
                        m_held  = 0;
                        break;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, predict the result and wait until it is visible.
    task automatic step(input logic r, input logic en, input logic [N-1:0] rq, input logic d);
        exp_t e;
        rst    = r;
        enable = en;
        req    = rq;
        done   = d;
        model_update(r, en, rq, d);
        e.gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.idx = 4'(m_idx);
        e.to  = m_to;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Directed check against values worked out by hand from the arbitration rules.
    task automatic chk(input string name, input logic [N-1:0] g, input int i, input logic t);
        tests++;
        if (gnt_o !== g || gnt_idx_o !== 4'(i) || timeout_o !== t || gnt_valid_o !== (g != '0)) begin
            fails++;
            $display("FAIL %s: gnt=%h idx=%0d to=%b valid=%b, expected gnt=%h idx=%0d to=%b",
                     name, gnt_o, gnt_idx_o, timeout_o, gnt_valid_o, g, i, t);
        end
    endtask

    // Monitor: compare every presented output against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (gnt_o !== e.gnt || gnt_idx_o !== e.idx || timeout_o !== e.to ||
                    gnt_valid_o !== (e.gnt != '0)) begin
                    fails++;
                    $display("FAIL scoreboard @%0t: gnt=%h idx=%0d to=%b valid=%b, expected gnt=%h idx=%0d to=%b",
                             $time, gnt_o, gnt_idx_o, timeout_o, gnt_valid_o, e.gnt, e.idx, e.to);
                end
                tests++;
                if ($countones(gnt_o) > 1) begin
                    fails++;
                    $display("FAIL onehot @%0t: gnt=%h, expected at most one bit set", $time, gnt_o);
                end
            end
        end
    end

    initial begin
        int rr_exp[6] = '{6, 12, 13, 14, 15, 6};
        logic [N-1:0] rq;
        rst    = 1'b1;
        enable = 1'b0;
        req    = '0;
        done   = 1'b0;
        @(negedge clk);

        // Reset and basic grant / done / guard gap
        step(1, 1, 16'h0022, 0); chk("reset0", '0, 0, 0);
        step(1, 1, 16'h0022, 0); chk("reset1", '0, 0, 0);
        step(0, 1, 16'h0022, 0); chk("first_grant", 16'h0002, 1, 0);
        step(0, 1, 16'h0022, 1); chk("done_gap", '0, 1, 0);
        step(0, 1, 16'h0022, 0); chk("next_grant", 16'h0020, 5, 0);
        step(0, 1, 16'h0000, 0); chk("abort_gap", '0, 5, 0);
        step(0, 1, 16'h0000, 0); chk("idle_hold_idx", '0, 5, 0);

        // Round-robin wrap
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 16'hF040, 0); chk("rr_grant", N'(1) << rr_exp[k], rr_exp[k], 0);
            step(0, 1, 16'hF040, 1); chk("rr_gap", '0, rr_exp[k], 0);
        end

        // Abort and no preemption
        step(0, 1, 16'h0001, 0); chk("ab_grant0", 16'h0001, 0, 0);
        step(0, 1, 16'h0009, 0); chk("ab_nopreempt", 16'h0001, 0, 0);
        step(0, 1, 16'h0008, 0); chk("ab_drop", '0, 0, 0);
        step(0, 1, 16'h0008, 0); chk("ab_grant3", 16'h0008, 3, 0);
        step(0, 1, 16'h0000, 1); chk("ab_done", '0, 3, 0);

        // Timeout after MAX_HOLD cycles
        step(0, 1, 16'h8000, 0); chk("to_c1", 16'h8000, 15, 0);
        for (int k = 2; k <= MAXH; k++) begin
            step(0, 1, 16'h8000, 0); chk("to_hold", 16'h8000, 15, 0);
        end
        step(0, 1, 16'h8000, 0); chk("to_pulse", '0, 15, 1);
        step(0, 1, 16'h8000, 0); chk("to_regrant", 16'h8000, 15, 0);
        step(0, 1, 16'h8000, 1); chk("to_done", '0, 15, 0);

        // Enable corners
        step(0, 0, 16'h000F, 0); chk("en_off0", '0, 15, 0);
        step(0, 0, 16'h000F, 0); chk("en_off1", '0, 15, 0);
        step(0, 1, 16'h000F, 0); chk("en_grant", 16'h0001, 0, 0);
        step(0, 0, 16'h000F, 0); chk("en_drop_hold", 16'h0001, 0, 0);
        step(0, 0, 16'h000F, 1); chk("en_done", '0, 0, 0);
        step(0, 0, 16'h000F, 0); chk("en_nogrant0", '0, 0, 0);
        step(0, 0, 16'h000F, 0); chk("en_nogrant1", '0, 0, 0);

        // done_i in the same cycle as the timeout
        step(0, 1, 16'h000F, 0); chk("dt_grant", 16'h0002, 1, 0);
        for (int k = 2; k <= MAXH; k++) begin
            step(0, 1, 16'h000F, 0); chk("dt_hold", 16'h0002, 1, 0);
        end
        step(0, 1, 16'h000F, 1); chk("dt_no_pulse", '0, 1, 0);
        step(0, 0, 16'h000F, 0); chk("dt_idle", '0, 1, 0);

        // Reset in the middle of a grant
        step(0, 1, 16'h0004, 0); chk("rm_grant", 16'h0004, 2, 0);
        step(1, 1, 16'h0006, 0); chk("rm_reset", '0, 0, 0);
        step(0, 1, 16'h0006, 0); chk("rm_after", 16'h0002, 1, 0);
        step(0, 1, 16'h0006, 1); chk("rm_done", '0, 1, 0);

        // Random traffic, checked by the scoreboard only
        rq = 16'h0000;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rq = N'($urandom) & N'($urandom);
            end
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rq,
                 ($urandom_range(0, 4) == 0));
        end

        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ch_rr_arbiter.md
Name: ch_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream channel resource among 16 requesters. It converts a multi-hot channel request vector into a registered one-hot grant. It holds that grant until the owner signals completion, drops its request or exceeds a hold limit. It sits between the per-channel request logic and the one-hot channel-select datapath, and guarantees fair, glitch-free, never-overlapping ownership.

Parameters:
N_CH, 16, number of requesting channels (>=2)
MAX_HOLD, 255, max cycles a grant may be held; 0 disables the timeout
IDX_W, $clog2(N_CH), width of the channel index
CNT_W, $clog2(MAX_HOLD+1), hold-counter width (min 1)

Ports:
clk_i  in  1  clock, all logic on the rising edge
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  permits new grants; has no effect on a grant already active
req_i  in  N_CH  per-channel request, multi-hot allowed
done_i  in  1  owner finished; sampled only while granted
gnt_o  out  N_CH  registered one-hot grant, or all zero
gnt_valid_o  out  1  high iff gnt_o != 0
gnt_idx_o  out  IDX_W  binary index of the granted channel; holds its last value when gnt_valid_o=0
timeout_o  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, timeout_o=0, rr pointer ptr=0, hold counter=0. Reset mid-grant revokes the grant on that same edge.
- FSM states: IDLE, GRANT, RELEASE.
- Arbitration (IDLE and RELEASE):
  - If enable_i=1 and req_i!=0, pick the first set bit searching upward from ptr, wrapping N_CH-1 -> 0.
  - The next edge loads gnt_o with that one-hot, sets gnt_idx_o, clears the counter and enters GRANT.
  - Otherwise the next state is IDLE.
- Latency: request present in an IDLE cycle t -> gnt_o asserted in cycle t+1.
- GRANT: gnt_o is held stable, and the counter increments each cycle while it is below MAX_HOLD. Release conditions, in priority order:
  1. done_i=1
  2. req_i[gnt_idx_o]=0 (abort)
  3. MAX_HOLD!=0 and counter==MAX_HOLD-1 (timeout)
- On release at edge t: gnt_o=0 in cycle t+1, state=RELEASE, ptr=(gnt_idx_o+1) mod N_CH. timeout_o=1 in cycle t+1 only if condition 3 alone caused the release.
- A grant therefore lasts at most MAX_HOLD cycles.
- RELEASE lasts exactly one cycle with gnt_o=0 (guard gap), and arbitrates using the updated ptr. The earliest new grant is t+2.
- ptr changes only on release. Requests arriving or dropping on non-granted channels never disturb an active grant (no preemption).
- done_i in IDLE or RELEASE is ignored.
- enable_i=0 while in GRANT: the grant runs to normal release, and no new grant follows until enable_i=1.
- Simultaneous done_i and timeout in the same cycle: treated as done, timeout_o stays 0.
- Single requester: the same channel is regranted after every RELEASE gap.
- Fairness: with all N_CH requesting continuously, each channel is granted exactly once per N_CH grants.
- Invariant: popcount(gnt_o) <= 1 in every cycle.

Decomposition:
- Package ch_arb_pkg:
  - arb_state_e enum {IDLE, GRANT, RELEASE}
  - localparam defaults N_CH_DEF=16, MAX_HOLD_DEF=255
  - function onehot2idx
- Sub-module rr_pick:
  - Purely combinational; inputs req, ptr; outputs found, idx, onehot.
  - Implementation: rotate req right by ptr, lowest-set-bit priority select, rotate back.
  - Unit-testable on its own. The FSM, counter, ptr and output registers stay in ch_rr_arbiter.

Test Plan:
- Reset/basic: rst_i=1 for 2 cycles with req_i=16'h0022 -> all outputs 0; release reset -> next cycle gnt_o=16'h0002, gnt_idx_o=1; done_i pulse -> gnt_o=0 one cycle, then gnt_o=16'h0020, idx=5.
- Round-robin wrap: req_i=16'hF040 held, done_i pulsed each grant -> grant order idx 6,12,13,14,15,6 with a 1-cycle zero gap between each.
- Abort and no preemption: granted ch0 (req_i=16'h0001); raise req bit 3 -> gnt_o stays 16'h0001; drop bit 0 -> gnt_o=0, then 16'h0008, timeout_o=0.
- Timeout: MAX_HOLD=4, req_i=16'h8000 held, no done_i -> gnt_o=16'h8000 for exactly 4 cycles, timeout_o=1 in the following gap cycle, then regrant of idx 15.
- Enable/done corners: enable_i=0 with req_i=16'h000F -> no grant; enable_i=1 -> idx 0; enable_i=0 mid-grant -> grant held until done_i, no new grant afterwards. done_i together with the timeout cycle -> timeout_o=0.
- Reset mid-grant: rst_i=1 while gnt_o=16'h0004 -> next cycle gnt_o=0 and ptr=0; with req_i=16'h0006 the first grant after reset is idx 1.
